// File: rtl/des_in_stage.sv
// des_in_stage: accepts a DES block/key, applies IP and PC-1 plus key parity check,
// and issues it to the round controller with its fixed sampling timing.
module des_in_stage #(
   parameter bit CHECK_PARITY = 1'b1
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        blk_in_valid,
   output logic        blk_in_ready,
   input  logic [63:0] blk_in_data,
   input  logic [63:0] blk_in_key,
   input  logic        blk_in_mode,
   input  logic        encrypt_ready_in,
   output logic        encrypt_out_valid,
   output logic        mode_out,
   output logic        data_out_valid,
   output logic [31:0] left_data_out,
   output logic [31:0] right_data_out,
   output logic [55:0] sub_key_out,
   output logic        sub_key_out_valid,
   output logic        check_error_out,
   output logic        err_out_valid
);
   localparam int IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2,
      60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6,
      64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1,
      59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5,
      63, 55, 47, 39, 31, 23, 15, 7
   };
   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_HOLD, S_BLIND, S_WAIT} state_t;
   state_t      state;
   logic [63:0] ip_data;
   logic [55:0] pc1_key;
   logic [7:0]  byte_odd;
   logic        key_err;
   // FIPS bit n lives at vector index 64-n
   for (genvar i = 0; i < 64; i++) begin : g_ip
      assign ip_data[63-i] = blk_in_data[64-IP_T[i]];
   end
   for (genvar i = 0; i < 56; i++) begin : g_pc1
      assign pc1_key[55-i] = blk_in_key[64-PC1_T[i]];
   end
   for (genvar i = 0; i < 8; i++) begin : g_par
      assign byte_odd[i] = ^blk_in_key[8*i +: 8];
   end
   assign key_err = CHECK_PARITY & ~&byte_odd;
   // Controller's ready flag is one cycle stale, so it is only trusted from S_WAIT on
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state             <= S_IDLE;
         blk_in_ready      <= 1'b1;
         encrypt_out_valid <= 1'b0;
         data_out_valid    <= 1'b0;
         sub_key_out_valid <= 1'b0;
         err_out_valid     <= 1'b0;
         mode_out          <= 1'b0;
         left_data_out     <= '0;
         right_data_out    <= '0;
         sub_key_out       <= '0;
         check_error_out   <= 1'b0;
      end else begin
         encrypt_out_valid <= 1'b0;
         data_out_valid    <= 1'b0;
         sub_key_out_valid <= 1'b0;
         err_out_valid     <= 1'b0;
         case (state)
            S_IDLE: if (blk_in_valid) begin
               state             <= S_ISSUE;
               blk_in_ready      <= 1'b0;
               encrypt_out_valid <= 1'b1;
               data_out_valid    <= 1'b1;
               sub_key_out_valid <= 1'b1;
               err_out_valid     <= key_err;
               mode_out          <= blk_in_mode;
               left_data_out     <= ip_data[63:32];
               right_data_out    <= ip_data[31:0];
               sub_key_out       <= pc1_key;
               check_error_out   <= key_err;
            end
            S_ISSUE: state <= S_HOLD;
            S_HOLD:  state <= S_BLIND;
            S_BLIND: state <= S_WAIT;
            S_WAIT: if (encrypt_ready_in) begin
               state        <= S_IDLE;
               blk_in_ready <= 1'b1;
            end
            default: begin
               state        <= S_IDLE;
               blk_in_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_des_in_stage.sv
// tb_des_in_stage: directed checks of des_in_stage timing, permutations and parity.
module tb_des_in_stage;
   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic        blk_in_valid = 1'b0;
   logic        blk_in_ready;
   logic [63:0] blk_in_data = '0;
   logic [63:0] blk_in_key = '0;
   logic        blk_in_mode = 1'b0;
   logic        encrypt_ready_in = 1'b0;
   logic        encrypt_out_valid, mode_out, data_out_valid, sub_key_out_valid;
   logic        check_error_out, err_out_valid;
   logic [31:0] left_data_out, right_data_out;
   logic [55:0] sub_key_out;
   int total = 0;
   int bad = 0;

   localparam logic [63:0] FIPS_KEY  = 64'h133457799BBCDFF1;
   localparam logic [63:0] FIPS_DATA = 64'h0123456789ABCDEF;
   localparam logic [63:0] ZK_KEY    = 64'h0101010101010101;
   localparam logic [63:0] ONES      = 64'hFFFFFFFFFFFFFFFF;

   des_in_stage #(.CHECK_PARITY(1'b1)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .blk_in_valid(blk_in_valid), .blk_in_ready(blk_in_ready),
      .blk_in_data(blk_in_data), .blk_in_key(blk_in_key), .blk_in_mode(blk_in_mode),
      .encrypt_ready_in(encrypt_ready_in), .encrypt_out_valid(encrypt_out_valid),
      .mode_out(mode_out), .data_out_valid(data_out_valid),
      .left_data_out(left_data_out), .right_data_out(right_data_out),
      .sub_key_out(sub_key_out), .sub_key_out_valid(sub_key_out_valid),
      .check_error_out(check_error_out), .err_out_valid(err_out_valid)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // {ready, encrypt_valid, data_valid, key_valid, err_valid}
   function automatic logic [63:0] ctl();
      return {59'd0, blk_in_ready, encrypt_out_valid, data_out_valid, sub_key_out_valid, err_out_valid};
   endfunction

   task automatic chk_blk(input string tag, input logic [31:0] l, input logic [31:0] r,
                          input logic [55:0] k, input logic m, input logic e);
      chk({tag, "_left"}, {32'd0, left_data_out}, {32'd0, l});
      chk({tag, "_right"}, {32'd0, right_data_out}, {32'd0, r});
      chk({tag, "_key"}, {8'd0, sub_key_out}, {8'd0, k});
      chk({tag, "_mode_err"}, {62'd0, mode_out, check_error_out}, {62'd0, m, e});
   endtask

   initial begin
      repeat (2) @(negedge clk_in);
      chk("rst_ctl_async", ctl(), 64'b10000);
      chk_blk("rst", '0, '0, '0, 1'b0, 1'b0);
      rst_n_in = 1'b1;
      step();
      chk("idle_ctl", ctl(), 64'b10000);

      // FIPS vector with encrypt_ready_in stuck at 1 (stale ready)
      encrypt_ready_in = 1'b1;
      blk_in_valid = 1'b1; blk_in_data = FIPS_DATA; blk_in_key = FIPS_KEY; blk_in_mode = 1'b0;
      step();
      chk("fips_T_ctl", ctl(), 64'b01110);
      chk_blk("fips", 32'hCC00CCFF, 32'hF0AAF0AA, 56'hF0CCAAF556678F, 1'b0, 1'b0);
      blk_in_data = ONES; blk_in_key = ZK_KEY; blk_in_mode = 1'b1;
      step();
      chk("fips_T1_ctl", ctl(), 64'b00000);
      chk_blk("fips_hold", 32'hCC00CCFF, 32'hF0AAF0AA, 56'hF0CCAAF556678F, 1'b0, 1'b0);
      step();
      chk("stale_T2_ctl", ctl(), 64'b00000);
      step();
      chk("stale_T3_ctl", ctl(), 64'b00000);
      step();
      chk("stale_T4_ctl", ctl(), 64'b10000);
      step();
      chk("zk_T5_ctl", ctl(), 64'b01110);
      chk_blk("zk", 32'hFFFFFFFF, 32'hFFFFFFFF, 56'h0, 1'b1, 1'b0);
      blk_in_valid = 1'b0;
      for (int i = 0; i < 20 && !blk_in_ready; i++) step();
      chk("wait_idle1", {63'd0, blk_in_ready}, 64'd1);

      // Parity error with encrypt_ready_in 1 at T+1, 0 at T+2, 1 at T+3
      blk_in_valid = 1'b1; blk_in_data = '0; blk_in_key = '0; blk_in_mode = 1'b0;
      step();
      chk("par_T_ctl", ctl(), 64'b01111);
      chk_blk("par", '0, '0, '0, 1'b0, 1'b1);
      blk_in_valid = 1'b0;
      step();
      chk("par_T1_ctl", ctl(), 64'b00000);
      encrypt_ready_in = 1'b0;
      step();
      encrypt_ready_in = 1'b1;
      step();
      chk("par_T3_ctl", ctl(), 64'b00000);
      step();
      chk("par_T4_ctl", ctl(), 64'b10000);
      chk("par_err_level_held", {63'd0, check_error_out}, 64'd1);

      // Back-pressure: valid held high, controller busy for 70 cycles
      blk_in_valid = 1'b1; blk_in_data = FIPS_DATA; blk_in_key = FIPS_KEY; blk_in_mode = 1'b1;
      encrypt_ready_in = 1'b0;
      step();
      chk("bp_T_ctl", ctl(), 64'b01110);
      blk_in_data = '0; blk_in_key = ZK_KEY; blk_in_mode = 1'b0;
      step();
      step();
      for (int i = 0; i < 70; i++) begin
         step();
         chk("bp_wait_ctl", ctl(), 64'b00000);
         chk("bp_stable", {left_data_out, right_data_out}, 64'hCC00CCFFF0AAF0AA);
      end
      chk_blk("bp_end", 32'hCC00CCFF, 32'hF0AAF0AA, 56'hF0CCAAF556678F, 1'b1, 1'b0);
      encrypt_ready_in = 1'b1;
      step();
      chk("bp_idle_ctl", ctl(), 64'b10000);
      step();
      chk("bp_accept_ctl", ctl(), 64'b01110);
      chk_blk("bp_new", '0, '0, '0, 1'b0, 1'b0);
      blk_in_valid = 1'b0;
      for (int i = 0; i < 20 && !blk_in_ready; i++) step();
      chk("wait_idle2", {63'd0, blk_in_ready}, 64'd1);

      // Reset during S_HOLD drops the block
      blk_in_valid = 1'b1; blk_in_data = FIPS_DATA; blk_in_key = FIPS_KEY; blk_in_mode = 1'b1;
      step();
      chk("rm_T_ctl", ctl(), 64'b01110);
      blk_in_valid = 1'b0;
      step();
      rst_n_in = 1'b0;
      #1;
      chk("rm_async_ctl", ctl(), 64'b10000);
      chk_blk("rm_async", '0, '0, '0, 1'b0, 1'b0);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      step();
      chk("rm_after_ctl", ctl(), 64'b10000);
      chk_blk("rm_after", '0, '0, '0, 1'b0, 1'b0);
      blk_in_valid = 1'b1; blk_in_data = ONES; blk_in_key = ZK_KEY; blk_in_mode = 1'b1;
      step();
      chk("rm_next_ctl", ctl(), 64'b01110);
      chk_blk("rm_next", 32'hFFFFFFFF, 32'hFFFFFFFF, 56'h0, 1'b1, 1'b0);
      blk_in_valid = 1'b0;
      step();
      chk("rm_next_T1_ctl", ctl(), 64'b00000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
